control_unit: RTL and testbench

//   Multi-cycle control FSM for the RISC-V datapath (fd). Consumes opcode/funct3 from the

---
 rtl/control_unit_if.sv | 32 +++
 rtl/control_unit.sv | 216 +++++++++++++++++++++
 tb/tb_control_unit.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// Bundle of control-unit inputs (decode fields, ALU flags, memory readies) and all
// datapath/memory strobes. master = control unit, slave = datapath and memories.
interface control_unit_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [3:0] alu_flags;
  logic       i_mem_ready;
  logic       d_mem_ready;
  logic       i_mem_re;
  logic       d_mem_re;
  logic       d_mem_we;
  logic       ir_we;
  logic       pc_we;
  logic       rf_we;
  logic [3:0] alu_cmd;
  logic       alu_src;
  logic       pc_src;
  logic       rf_src;
  logic       error;

  modport master (
    input  opcode, funct3, alu_flags, i_mem_ready, d_mem_ready,
    output i_mem_re, d_mem_re, d_mem_we, ir_we, pc_we, rf_we,
           alu_cmd, alu_src, pc_src, rf_src, error
  );

  modport slave (
    output opcode, funct3, alu_flags, i_mem_ready, d_mem_ready,
    input  i_mem_re, d_mem_re, d_mem_we, ir_we, pc_we, rf_we,
           alu_cmd, alu_src, pc_src, rf_src, error
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RISC-V datapath; drives all
// datapath selects, PC/IR strobes and memory handshakes, with a sticky ERROR trap.
module control_unit #(
  parameter int WAIT_MAX  = 15,
  parameter int WAIT_BITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  control_unit_if.master bus
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [3:0] CMD_R  = 4'b0000;
  localparam logic [3:0] CMD_I  = 4'b0001;
  localparam logic [3:0] CMD_S  = 4'b0010;
  localparam logic [3:0] CMD_SB = 4'b0011;
  localparam logic [3:0] CMD_U  = 4'b0100;
  localparam logic [3:0] CMD_UJ = 4'b0101;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    ERROR  = 3'd5
  } state_t;

  state_t               state, state_nx;
  logic [WAIT_BITS-1:0] wait_cnt, wait_nx;
  logic [6:0]           op_q;
  logic [2:0]           f3_q;
  logic                 wait_expired;

  logic       i_mem_re, d_mem_re, d_mem_we, ir_we, pc_we, rf_we;
  logic [3:0] alu_cmd;
  logic       alu_src, pc_src, rf_src, error;

  logic unused_flag;
  assign unused_flag = bus.alu_flags[3];

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LD, OP_SD, OP_BR, OP_JAL, OP_LUI: is_legal = 1'b1;
      default:                                         is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] cmd_of(input logic [6:0] op);
    case (op)
      OP_I, OP_LD: cmd_of = CMD_I;
      OP_SD:       cmd_of = CMD_S;
      OP_BR:       cmd_of = CMD_SB;
      OP_LUI:      cmd_of = CMD_U;
      OP_JAL:      cmd_of = CMD_UJ;
      default:     cmd_of = CMD_R;
    endcase
  endfunction

  function automatic logic uses_imm(input logic [6:0] op);
    uses_imm = (op != OP_R) && (op != OP_BR);
  endfunction

  function automatic logic br_f3_ok(input logic [2:0] f3);
    br_f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // Signed less-than is MSB xor overflow of the ALU subtraction.
  function automatic logic br_taken(input logic [2:0] f3, input logic [3:0] flags);
    case (f3)
      3'b000:  br_taken = flags[0];
      3'b001:  br_taken = ~flags[0];
      3'b100:  br_taken = flags[1] ^ flags[2];
      3'b101:  br_taken = ~(flags[1] ^ flags[2]);
      default: br_taken = 1'b0;
    endcase
  endfunction

  assign wait_expired = (wait_cnt == WAIT_BITS'(WAIT_MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      wait_cnt <= '0;
      op_q     <= '0;
      f3_q     <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      if (state == DECODE) begin
        op_q <= bus.opcode;
        f3_q <= bus.funct3;
      end
    end
  end

  always_comb begin
    state_nx = state;
    wait_nx  = '0;
    i_mem_re = 1'b0;
    d_mem_re = 1'b0;
    d_mem_we = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    rf_we    = 1'b0;
    alu_cmd  = CMD_R;
    alu_src  = 1'b0;
    pc_src   = 1'b0;
    rf_src   = 1'b0;
    error    = 1'b0;

    case (state)
      FETCH: begin
        i_mem_re = 1'b1;
        if (bus.i_mem_ready) begin
          ir_we    = 1'b1;
          state_nx = DECODE;
        end else if (wait_expired) begin
          state_nx = ERROR;
        end else begin
          wait_nx = wait_cnt + WAIT_BITS'(1);
        end
      end

      DECODE: state_nx = is_legal(bus.opcode) ? EXEC : ERROR;

      EXEC: begin
        alu_cmd = cmd_of(op_q);
        alu_src = uses_imm(op_q);
        if (op_q == OP_BR) begin
          if (br_f3_ok(f3_q)) begin
            pc_we    = 1'b1;
            pc_src   = br_taken(f3_q, bus.alu_flags);
            state_nx = FETCH;
          end else begin
            state_nx = ERROR;
          end
        end else if ((op_q == OP_LD) || (op_q == OP_SD)) begin
          state_nx = MEM;
        end else begin
          state_nx = WB;
        end
      end

      // ALU command/source stay on the EXEC values so the address holds during the access.
      MEM: begin
        alu_cmd = cmd_of(op_q);
        alu_src = uses_imm(op_q);
        if (op_q == OP_LD) d_mem_re = 1'b1;
        else               d_mem_we = 1'b1;
        if (bus.d_mem_ready) begin
          if (op_q == OP_LD) begin
            state_nx = WB;
          end else begin
            pc_we    = 1'b1;
            state_nx = FETCH;
          end
        end else if (wait_expired) begin
          state_nx = ERROR;
        end else begin
          wait_nx = wait_cnt + WAIT_BITS'(1);
        end
      end

      // JAL writes its link (pc+4) through the ALU under UJ, so the command stays up here.
      WB: begin
        alu_cmd  = cmd_of(op_q);
        alu_src  = uses_imm(op_q);
        rf_we    = 1'b1;
        pc_we    = 1'b1;
        rf_src   = (op_q == OP_LD);
        pc_src   = (op_q == OP_JAL);
        state_nx = FETCH;
      end

      ERROR: error = 1'b1;

      default: state_nx = FETCH;
    endcase

    // Outputs are forced low for the whole reset pulse so an aborted access stops at once.
    if (rst) begin
      i_mem_re = 1'b0;
      d_mem_re = 1'b0;
      d_mem_we = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      rf_we    = 1'b0;
      alu_cmd  = CMD_R;
      alu_src  = 1'b0;
      pc_src   = 1'b0;
      rf_src   = 1'b0;
      error    = 1'b0;
    end
  end

  assign bus.i_mem_re = i_mem_re;
  assign bus.d_mem_re = d_mem_re;
  assign bus.d_mem_we = d_mem_we;
  assign bus.ir_we    = ir_we;
  assign bus.pc_we    = pc_we;
  assign bus.rf_we    = rf_we;
  assign bus.alu_cmd  = alu_cmd;
  assign bus.alu_src  = alu_src;
  assign bus.pc_src   = pc_src;
  assign bus.rf_src   = rf_src;
  assign bus.error    = error;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: each instruction is expanded by a transaction-level model into
// per-cycle expected strobes and ready stimulus, then replayed against the DUT.
module tb_control_unit;
  localparam int WAIT_MAX = 15;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef struct packed {
    logic       i_re, d_re, d_we, ir_we, pc_we, rf_we;
    logic [3:0] cmd;
    logic       asrc, psrc, rsrc, err;
  } outv_t;

  typedef struct packed {
    logic  ir;
    logic  dr;
    outv_t exp;
    int    ph;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  control_unit_if bus();

  control_unit #(.WAIT_MAX(WAIT_MAX), .WAIT_BITS(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int    tests = 0;
  int    fails = 0;
  int    instr_no = 0;
  step_t q[$];

  function automatic string tag_name(input int ph);
    case (ph)
      0:       return "fetch";
      1:       return "decode";
      2:       return "exec";
      3:       return "mem";
      4:       return "wb";
      5:       return "error";
      6:       return "reset";
      default: return "rst_mid_sd";
    endcase
  endfunction

  function automatic outv_t observed();
    outv_t v;
    v = {bus.i_mem_re, bus.d_mem_re, bus.d_mem_we, bus.ir_we, bus.pc_we, bus.rf_we,
         bus.alu_cmd, bus.alu_src, bus.pc_src, bus.rf_src, bus.error};
    return v;
  endfunction

  task automatic check(input string tag, input outv_t exp);
    outv_t obs;
    obs = observed();
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s instr=%0d observed=%h required=%h", tag, instr_no, obs, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic ir, input logic dr, input outv_t e, input int ph);
    step_t s;
    s.ir = ir; s.dr = dr; s.exp = e; s.ph = ph;
    q.push_back(s);
  endtask

  // Transaction model: what each instruction looks like cycle by cycle.
  task automatic gen(input logic [6:0] op, input logic [2:0] f3, input logic [3:0] fl,
                     input int idly, input int ddly, output bit err);
    outv_t v, base;
    logic  legal, taken, f3_ok, is_mem;
    logic [3:0] cmd;
    int    n;
    err = 0;

    n = (idly < WAIT_MAX) ? idly : WAIT_MAX;
    for (int k = 0; k < n; k++) begin
      v = '0; v.i_re = 1'b1;
      push(1'b0, rbit(), v, 0);
    end
    if (idly >= WAIT_MAX) begin err = 1; return; end
    v = '0; v.i_re = 1'b1; v.ir_we = 1'b1;
    push(1'b1, rbit(), v, 0);

    push(rbit(), rbit(), '0, 1);

    legal = 1'b1;
    case (op)
      OP_R:        cmd = 4'd0;
      OP_I, OP_LD: cmd = 4'd1;
      OP_SD:       cmd = 4'd2;
      OP_BR:       cmd = 4'd3;
      OP_LUI:      cmd = 4'd4;
      OP_JAL:      cmd = 4'd5;
      default: begin cmd = 4'd0; legal = 1'b0; end
    endcase
    if (!legal) begin err = 1; return; end

    base = '0;
    base.cmd  = cmd;
    base.asrc = !(op == OP_R || op == OP_BR);

    if (op == OP_BR) begin
      f3_ok = 1'b1;
      case (f3)
        3'b000:  taken = fl[0];
        3'b001:  taken = !fl[0];
        3'b100:  taken = fl[1] != fl[2];
        3'b101:  taken = fl[1] == fl[2];
        default: begin taken = 1'b0; f3_ok = 1'b0; end
      endcase
      v = base;
      if (f3_ok) begin v.pc_we = 1'b1; v.psrc = taken; end
      push(rbit(), rbit(), v, 2);
      if (!f3_ok) err = 1;
      return;
    end

    push(rbit(), rbit(), base, 2);

    is_mem = (op == OP_LD) || (op == OP_SD);
    if (is_mem) begin
      v = base;
      if (op == OP_LD) v.d_re = 1'b1; else v.d_we = 1'b1;
      n = (ddly < WAIT_MAX) ? ddly : WAIT_MAX;
      for (int k = 0; k < n; k++) push(rbit(), 1'b0, v, 3);
      if (ddly >= WAIT_MAX) begin err = 1; return; end
      if (op == OP_SD) v.pc_we = 1'b1;
      push(rbit(), 1'b1, v, 3);
      if (op == OP_SD) return;
    end

    v = base;
    v.rf_we = 1'b1; v.pc_we = 1'b1;
    v.rsrc  = (op == OP_LD);
    v.psrc  = (op == OP_JAL);
    push(rbit(), rbit(), v, 4);
  endtask

  task automatic run_n(input int n);
    step_t s;
    for (int k = 0; k < n && q.size() > 0; k++) begin
      s = q.pop_front();
      @(negedge clk);
      bus.i_mem_ready = s.ir;
      bus.d_mem_ready = s.dr;
      #1;
      check(tag_name(s.ph), s.exp);
    end
  endtask

  // Reset pulse released just after a rising edge so the next instruction starts in FETCH.
  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    bus.i_mem_ready = rbit();
    bus.d_mem_ready = rbit();
    #1;
    check("reset", '0);
    @(posedge clk);
    #1;
    check("reset", '0);
    bus.i_mem_ready = 1'b0;
    bus.d_mem_ready = 1'b0;
    rst = 1'b0;
  endtask

  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic [3:0] fl,
                          input int idly, input int ddly);
    bit    err;
    outv_t ev;
    instr_no++;
    bus.opcode    = op;
    bus.funct3    = f3;
    bus.alu_flags = fl;
    gen(op, f3, fl, idly, ddly, err);
    if (err) begin
      ev = '0; ev.err = 1'b1;
      for (int k = 0; k < 3; k++) push(rbit(), rbit(), ev, 5);
    end
    run_n(q.size());
    if (err) reset_pulse();
  endtask

  function automatic int rand_delay();
    if ($urandom_range(0, 19) == 0) return int'($urandom_range(13, 16));
    return int'($urandom_range(0, 3));
  endfunction

  logic [6:0] legal_ops [7];
  logic [6:0] rop;
  bit         dummy;

  initial begin
    legal_ops = '{OP_R, OP_I, OP_LD, OP_SD, OP_BR, OP_JAL, OP_LUI};
    bus.opcode      = '0;
    bus.funct3      = '0;
    bus.alu_flags   = '0;
    bus.i_mem_ready = 1'b0;
    bus.d_mem_ready = 1'b0;

    @(negedge clk);
    bus.i_mem_ready = 1'b1;
    #1;
    check("reset", '0);
    @(posedge clk);
    #1;
    check("reset", '0);
    bus.i_mem_ready = 1'b0;
    rst = 1'b0;

    do_instr(OP_R,   3'b000, 4'b0000, 0, 0);
    do_instr(OP_LD,  3'b011, 4'b0000, 0, 3);
    do_instr(OP_BR,  3'b000, 4'b0001, 0, 0);
    do_instr(OP_BR,  3'b000, 4'b0000, 0, 0);
    do_instr(OP_BR,  3'b001, 4'b0000, 1, 0);
    do_instr(OP_BR,  3'b100, 4'b0110, 0, 0);
    do_instr(OP_BR,  3'b100, 4'b0010, 0, 0);
    do_instr(OP_BR,  3'b101, 4'b0100, 0, 0);
    do_instr(OP_JAL, 3'b000, 4'b0000, 0, 0);
    do_instr(OP_LUI, 3'b000, 4'b0000, 2, 0);
    do_instr(OP_I,   3'b000, 4'b0000, 0, 0);
    do_instr(7'b1111111, 3'b000, 4'b0000, 0, 0);
    do_instr(OP_R,   3'b000, 4'b0000, 14, 0);
    do_instr(OP_R,   3'b000, 4'b0000, 15, 0);
    do_instr(OP_LD,  3'b011, 4'b0000, 0, 14);
    do_instr(OP_SD,  3'b011, 4'b0000, 0, 15);
    do_instr(OP_SD,  3'b011, 4'b0000, 0, 0);
    do_instr(OP_BR,  3'b010, 4'b0000, 0, 0);

    // Store interrupted by reset during its data-memory wait.
    instr_no++;
    bus.opcode = OP_SD; bus.funct3 = 3'b011; bus.alu_flags = '0;
    gen(OP_SD, 3'b011, 4'b0000, 0, 6, dummy);
    run_n(5);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_sd", '0);
    q.delete();
    @(posedge clk);
    #1;
    check("rst_mid_sd", '0);
    bus.i_mem_ready = 1'b0;
    bus.d_mem_ready = 1'b0;
    rst = 1'b0;
    do_instr(OP_R, 3'b000, 4'b0000, 3, 0);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) rop = 7'($urandom_range(0, 127));
      else                           rop = legal_ops[$urandom_range(0, 6)];
      do_instr(rop, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
               rand_delay(), rand_delay());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
